// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg
// Shared types and helpers for the multi-cycle shift/rotate unit.
//   shift_mode_t : Shift_func_sel encodings (6 and 7 are reserved).
//   state_t      : controller states, exported on the debug port.
//   shift_width(): distance-port width for a given data width.
// Optional build macro used by the unit: ALU_SHIFT_CARRY_OUT_EN.
package alu_shift_pkg;

    typedef enum logic [2:0] {
        SHIFT_SRL = 3'd0,
        SHIFT_SRA = 3'd1,
        SHIFT_ROR = 3'd2,
        SHIFT_RRC = 3'd3,
        SHIFT_SLL = 3'd4,
        SHIFT_ROL = 3'd5
    } shift_mode_t;

    // Highest encoding that names a real operation.
    localparam logic [2:0] SHIFT_LAST_VALID = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int shift_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step
// Combinational single-step shifter: moves the working word by 0..STEP_BITS
// positions in the selected mode and reports the carry that results.
// Ports:
//   data, carry     : current working word and carry bit
//   mode            : shift_mode_t operation
//   step            : positions to move this cycle (0 = pass through)
//   next_data       : word after the step
//   next_carry      : last bit shifted out / wrapped (RRC: new carry);
//                     carry is passed through unchanged when step is 0
//                     or the mode is reserved
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP_BITS  = 8,
    localparam int SW         = $clog2(STEP_BITS + 1),
    localparam int AW         = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  carry,
    input  shift_mode_t           mode,
    input  logic [SW-1:0]         step,
    output logic [DATA_WIDTH-1:0] next_data,
    output logic                  next_carry
);

    int                    k;
    logic [AW-1:0]         right_idx;
    logic [AW-1:0]         left_idx;
    logic [DATA_WIDTH:0]   rrc_word;
    logic [DATA_WIDTH:0]   rrc_rot;

    always_comb begin
        k          = int'(step);
        right_idx  = '0;
        left_idx   = '0;
        // Bit positions of the last bit leaving the right/left end.
        if (k != 0) begin
            right_idx = AW'(k - 1);
            left_idx  = AW'(DATA_WIDTH - k);
        end
        // RRC treats {carry, data} as one DATA_WIDTH+1 bit ring.
        rrc_word   = {carry, data};
        rrc_rot    = (rrc_word >> k) | (rrc_word << (DATA_WIDTH + 1 - k));
        next_data  = data;
        next_carry = carry;
        if (k != 0) begin
            case (mode)
                SHIFT_SRL: begin
                    next_data  = data >> k;
                    next_carry = data[right_idx];
                end
                SHIFT_SRA: begin
                    next_data  = $signed(data) >>> k;
                    next_carry = data[right_idx];
                end
                SHIFT_ROR: begin
                    next_data  = (data >> k) | (data << (DATA_WIDTH - k));
                    next_carry = data[right_idx];
                end
                SHIFT_RRC: begin
                    next_data  = rrc_rot[DATA_WIDTH-1:0];
                    next_carry = rrc_rot[DATA_WIDTH];
                end
                SHIFT_SLL: begin
                    next_data  = data << k;
                    next_carry = data[left_idx];
                end
                SHIFT_ROL: begin
                    next_data  = (data << k) | (data >> (DATA_WIDTH - k));
                    next_carry = data[left_idx];
                end
                default: begin
                    next_data  = data;
                    next_carry = carry;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_unit_seq.sv
// alu_shift_unit_seq
// Multi-cycle shift/rotate unit. A request is latched on Start in IDLE; the
// RUN state then moves the working word by at most STEP_BITS positions per
// clock until the requested distance is consumed, loads Shift_Out and pulses
// Done for one cycle.
// Handshake: Start is sampled only in IDLE (ignored, not queued, in RUN);
// Busy is high exactly while in RUN; Done is a single-cycle pulse that
// appears with Busy already low, and a Start in that cycle is accepted.
// Abort cancels a RUN with no Done and wins over both completion and Start.
// Ports:
//   Clock, Reset_n      : clock (rising edge), async active-low reset
//   Start, Abort        : request / cancel
//   Op_Input            : operand
//   Shift_distance      : distance, $clog2(DATA_WIDTH) bits
//   Shift_func_sel      : mode (see alu_shift_pkg::shift_mode_t)
//   C                   : initial carry for RRC
//   Busy, Done          : status
//   Shift_Out           : registered result
//   Carry_Out           : last bit out (only with ALU_SHIFT_CARRY_OUT_EN)
//   dbg_state           : controller state for observation
// Build macro: ALU_SHIFT_CARRY_OUT_EN adds the Carry_Out port and register.
module alu_shift_unit_seq
    import alu_shift_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP_BITS  = 8,
    localparam int SHW        = shift_width(DATA_WIDTH),
    localparam int SW         = $clog2(STEP_BITS + 1)
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [DATA_WIDTH-1:0] Op_Input,
    input  logic [SHW-1:0]        Shift_distance,
    input  logic [2:0]            Shift_func_sel,
    input  logic                  C,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Shift_Out,
`ifdef ALU_SHIFT_CARRY_OUT_EN
    output logic                  Carry_Out,
`endif
    output state_t                dbg_state
);

    state_t                state;
    shift_mode_t           mode_r;
    logic [DATA_WIDTH-1:0] work_data;
    logic                  work_carry;
    logic [SHW-1:0]        remaining;
    logic [SW-1:0]         step_val;
    logic                  last_step;
    logic                  reserved_sel;
    logic [DATA_WIDTH-1:0] step_data;
    logic                  step_carry;
`ifdef ALU_SHIFT_CARRY_OUT_EN
    // Zero-distance and reserved requests leave Carry_Out untouched.
    logic                  zero_op;
`endif

    assign reserved_sel = (Shift_func_sel > SHIFT_LAST_VALID);

    always_comb begin
        step_val  = (remaining > SHW'(STEP_BITS)) ? SW'(STEP_BITS) : SW'(remaining);
        // Also true for remaining == 0, so distance 0 finishes on its first RUN edge.
        last_step = (remaining == SHW'(step_val));
    end

    alu_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP_BITS  (STEP_BITS)
    ) u_step (
        .data       (work_data),
        .carry      (work_carry),
        .mode       (mode_r),
        .step       (step_val),
        .next_data  (step_data),
        .next_carry (step_carry)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            mode_r     <= SHIFT_SRL;
            work_data  <= '0;
            work_carry <= 1'b0;
            remaining  <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Shift_Out  <= '0;
`ifdef ALU_SHIFT_CARRY_OUT_EN
            zero_op    <= 1'b0;
            Carry_Out  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Abort) begin
                        state      <= RUN;
                        Busy       <= 1'b1;
                        mode_r     <= shift_mode_t'(Shift_func_sel);
                        work_data  <= Op_Input;
                        work_carry <= C;
                        // Reserved modes run as a zero-distance pass-through.
                        remaining  <= reserved_sel ? '0 : Shift_distance;
`ifdef ALU_SHIFT_CARRY_OUT_EN
                        zero_op    <= reserved_sel || (Shift_distance == '0);
`endif
                    end
                end
                RUN: begin
                    if (Abort) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        work_data  <= step_data;
                        work_carry <= step_carry;
                        remaining  <= remaining - SHW'(step_val);
                        if (last_step) begin
                            state     <= IDLE;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                            Shift_Out <= step_data;
`ifdef ALU_SHIFT_CARRY_OUT_EN
                            if (!zero_op) begin
                                Carry_Out <= step_carry;
                            end
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_alu_shift_unit_seq.sv
// tb_alu_shift_unit_seq
// Directed plus randomised bench for alu_shift_unit_seq (DATA_WIDTH=32,
// STEP_BITS=8). Expected results go into a queue when a request is issued
// and are popped when Done is seen. Random cases use a bit-serial reference
// model. Inputs change on the falling edge, outputs are sampled there too.
// Carry_Out checks are compiled in with ALU_SHIFT_CARRY_OUT_EN.
module tb_alu_shift_unit_seq;
    import alu_shift_pkg::*;

    localparam int W   = 32;
    localparam int SB  = 8;
    localparam int SHW = 5;

    logic           Clock = 1'b0;
    logic           Reset_n;
    logic           Start;
    logic           Abort;
    logic [W-1:0]   Op_Input;
    logic [SHW-1:0] Shift_distance;
    logic [2:0]     Shift_func_sel;
    logic           C;
    logic           Busy;
    logic           Done;
    logic [W-1:0]   Shift_Out;
`ifdef ALU_SHIFT_CARRY_OUT_EN
    logic           Carry_Out;
`endif
    state_t         dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [0:0]   exp_c_q[$];
    logic [W-1:0] last_result;
    logic         model_carry;

    alu_shift_unit_seq #(
        .DATA_WIDTH (W),
        .STEP_BITS  (SB)
    ) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Start          (Start),
        .Abort          (Abort),
        .Op_Input       (Op_Input),
        .Shift_distance (Shift_distance),
        .Shift_func_sel (Shift_func_sel),
        .C              (C),
        .Busy           (Busy),
        .Done           (Done),
        .Shift_Out      (Shift_Out),
`ifdef ALU_SHIFT_CARRY_OUT_EN
        .Carry_Out      (Carry_Out),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // One bit per iteration; returns {carry, data}.
    function automatic logic [W:0] ref_shift(input logic [2:0] m, input logic [W-1:0] op,
                                             input int d, input logic c, input logic cprev);
        logic [W-1:0] x;
        logic         cy;
        logic         nc;
        x  = op;
        cy = (m == 3'd3) ? c : cprev;
        if (m > 3'd5 || d == 0) return {cprev, op};
        for (int i = 0; i < d; i++) begin
            case (m)
                3'd0: begin cy = x[0];   x = {1'b0, x[W-1:1]};  end
                3'd1: begin cy = x[0];   x = {x[W-1], x[W-1:1]}; end
                3'd2: begin cy = x[0];   x = {x[0], x[W-1:1]};  end
                3'd3: begin nc = x[0];   x = {cy, x[W-1:1]}; cy = nc; end
                3'd4: begin cy = x[W-1]; x = {x[W-2:0], 1'b0};  end
                default: begin cy = x[W-1]; x = {x[W-2:0], x[W-1]}; end
            endcase
        end
        return {cy, x};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after the Start edge.
    task automatic drive_start(input logic [2:0] m, input logic [W-1:0] op, input int d,
                               input logic c, input logic [W-1:0] exp_d, input logic exp_c,
                               input bit push);
        Shift_func_sel = m;
        Op_Input       = op;
        Shift_distance = SHW'(d);
        C              = c;
        Start          = 1'b1;
        if (push) begin
            exp_q.push_back(exp_d);
            exp_c_q.push_back(exp_c);
            model_carry = exp_c;
        end
        @(negedge Clock);
        Start          = 1'b0;
        // Inputs are don't-care once latched.
        Op_Input       = $urandom;
        Shift_distance = SHW'($urandom_range(0, 31));
        Shift_func_sel = 3'($urandom_range(0, 7));
        C              = 1'($urandom_range(0, 1));
    endtask

    // Counts falling edges from the current one until Done; Busy is counted
    // over the same window.
    task automatic wait_done(input string tag, input int exp_lat);
        int           lat;
        int           busy_cnt;
        logic [W-1:0] e;
        logic [0:0]   ec;
        busy_cnt = int'(Busy);
        lat      = 0;
        while (!Done && lat < 40) begin
            @(negedge Clock);
            lat++;
            if (!Done) busy_cnt += int'(Busy);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, "_busy_at_done"}, 64'(Busy), 64'(0));
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        ec = (exp_c_q.size() > 0) ? exp_c_q.pop_front() : '0;
        check({tag, "_result"}, 64'(Shift_Out), 64'(e));
`ifdef ALU_SHIFT_CARRY_OUT_EN
        check({tag, "_carry"}, 64'(Carry_Out), 64'(ec));
`else
        if (ec === 1'bx) $display("note: undefined carry expectation");
`endif
        last_result = e;
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input logic [W-1:0] op,
                          input int d, input logic c, input logic [W-1:0] exp_d,
                          input logic exp_c, input int exp_lat);
        drive_start(m, op, d, c, exp_d, exp_c, 1'b1);
        wait_done(tag, exp_lat);
        @(negedge Clock);
        check({tag, "_done_one_cycle"}, 64'(Done), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W:0]   r;
        logic [2:0]   m;
        logic [W-1:0] op;
        int           d;
        logic         c;
        int           lat;
        int           done_seen;

        Reset_n        = 1'b1;
        Start          = 1'b0;
        Abort          = 1'b0;
        Op_Input       = '0;
        Shift_distance = '0;
        Shift_func_sel = '0;
        C              = 1'b0;
        model_carry    = 1'b0;
        last_result    = '0;

        // reset state
        #2 Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_busy", 64'(Busy), 64'(0));
        check("reset_done", 64'(Done), 64'(0));
        check("reset_shift_out", 64'(Shift_Out), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(IDLE));
`ifdef ALU_SHIFT_CARRY_OUT_EN
        check("reset_carry", 64'(Carry_Out), 64'(0));
`endif
        Reset_n = 1'b1;
        @(negedge Clock);

        // basic modes and latency boundaries
        run_op("srl31", 3'd0, 32'h8000_0000, 31, 1'b0, 32'h0000_0001, 1'b0, 4);
        run_op("sra4",  3'd1, 32'h8000_0000, 4,  1'b0, 32'hF800_0000, 1'b0, 1);
        run_op("sra31", 3'd1, 32'h8000_0000, 31, 1'b0, 32'hFFFF_FFFF, 1'b0, 4);
        run_op("sll31", 3'd4, 32'h0000_0001, 31, 1'b0, 32'h8000_0000, 1'b0, 4);
        run_op("sll2",  3'd4, 32'h4000_0000, 2,  1'b0, 32'h0000_0000, 1'b1, 1);
        run_op("srl8",  3'd0, 32'hA5A5_A5A5, 8,  1'b0, 32'h00A5_A5A5, 1'b1, 1);
        run_op("srl9",  3'd0, 32'hA5A5_A5A5, 9,  1'b0, 32'h0052_D2D2, 1'b1, 2);
        run_op("rrc1",  3'd3, 32'h0000_0001, 1,  1'b1, 32'h8000_0000, 1'b1, 1);
        run_op("rrc2",  3'd3, 32'h0000_0001, 2,  1'b1, 32'hC000_0000, 1'b0, 1);
        run_op("rol8",  3'd5, 32'h1234_5678, 8,  1'b0, 32'h3456_7812, 1'b0, 1);
        run_op("ror4",  3'd2, 32'h1234_5678, 4,  1'b0, 32'h8123_4567, 1'b1, 1);
        run_op("dist0", 3'd0, 32'h1234_5678, 0,  1'b0, 32'h1234_5678, 1'b1, 1);
        run_op("rrc0",  3'd3, 32'h0F0F_0F0F, 0,  1'b0, 32'h0F0F_0F0F, 1'b1, 1);
        run_op("rsvd6", 3'd6, 32'hDEAD_BEEF, 9,  1'b0, 32'hDEAD_BEEF, 1'b1, 1);

        // Start pulsed during RUN is ignored; wait starts one edge later, so 3.
        drive_start(3'd0, 32'h8000_0000, 31, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        Start          = 1'b1;
        Op_Input       = 32'hFFFF_FFFF;
        Shift_distance = 5'd1;
        Shift_func_sel = 3'd4;
        @(negedge Clock);
        Start = 1'b0;
        wait_done("start_in_run", 3);
        @(negedge Clock);
        check("start_in_run_not_queued", 64'(Busy), 64'(0));
        check("start_in_run_no_extra_done", 64'(Done), 64'(0));

        // back-to-back: Start in the Done cycle
        drive_start(3'd5, 32'h1234_5678, 8, 1'b0, 32'h3456_7812, 1'b0, 1'b1);
        wait_done("b2b_first", 1);
        drive_start(3'd0, 32'hF000_0000, 20, 1'b0, 32'h0000_0F00, 1'b0, 1'b1);
        wait_done("b2b_second", 3);
        @(negedge Clock);
        check("b2b_done_one_cycle", 64'(Done), 64'(0));

        // Abort on the 2nd RUN cycle of a distance-31 operation
        drive_start(3'd4, 32'h0000_0001, 31, 1'b0, '0, 1'b0, 1'b0);
        @(negedge Clock);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        check("abort_busy", 64'(Busy), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done) done_seen++;
            @(negedge Clock);
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        check("abort_shift_out_kept", 64'(Shift_Out), 64'(last_result));
`ifdef ALU_SHIFT_CARRY_OUT_EN
        check("abort_carry_kept", 64'(Carry_Out), 64'(model_carry));
`endif

        // Abort on the completing edge beats completion
        drive_start(3'd0, 32'hFFFF_FFFF, 8, 1'b0, '0, 1'b0, 1'b0);
        Abort = 1'b1;
        @(negedge Clock);
        Abort = 1'b0;
        check("abort_last_no_done", 64'(Done), 64'(0));
        check("abort_last_shift_out", 64'(Shift_Out), 64'(last_result));

        // Start and Abort together in IDLE: request dropped
        Start          = 1'b1;
        Abort          = 1'b1;
        Op_Input       = 32'h5555_5555;
        Shift_distance = 5'd3;
        Shift_func_sel = 3'd0;
        @(negedge Clock);
        Start = 1'b0;
        Abort = 1'b0;
        check("start_abort_idle_busy", 64'(Busy), 64'(0));
        @(negedge Clock);
        check("start_abort_idle_done", 64'(Done), 64'(0));
        check("start_abort_idle_out", 64'(Shift_Out), 64'(last_result));

        // asynchronous reset mid-RUN
        drive_start(3'd0, 32'h8000_0000, 31, 1'b0, '0, 1'b0, 1'b0);
        @(negedge Clock);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(Busy), 64'(0));
        check("rst_mid_done", 64'(Done), 64'(0));
        check("rst_mid_shift_out", 64'(Shift_Out), 64'(0));
        check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
`ifdef ALU_SHIFT_CARRY_OUT_EN
        check("rst_mid_carry", 64'(Carry_Out), 64'(0));
`endif
        @(negedge Clock);
        Reset_n     = 1'b1;
        model_carry = 1'b0;
        last_result = '0;
        @(negedge Clock);
        check("rst_mid_no_done", 64'(Done), 64'(0));
        run_op("after_reset", 3'd3, 32'h0000_0001, 1, 1'b1, 32'h8000_0000, 1'b1, 1);

        // randomised operations against the bit-serial model
        for (int n = 0; n < 24; n++) begin
            m   = 3'($urandom_range(0, 7));
            op  = $urandom;
            d   = $urandom_range(0, 31);
            c   = 1'($urandom_range(0, 1));
            r   = ref_shift(m, op, d, c, model_carry);
            lat = (m > 3'd5 || d == 0) ? 1 : (d + SB - 1) / SB;
            run_op($sformatf("rand%0d_m%0d_d%0d", n, m, d), m, op, d, c, r[W-1:0], r[W], lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
